// File: rtl/wma_calculator.sv
// ---------------------------------------------------------------------------
// wma_calculator
//
// One-step weighted-moving-average update for the temperature-sensor path.
// A sample x is blended with the previous average WMA0. If x lies inside the
// band [T1, T2), both x and WMA0 get a weight of 3. Otherwise both get a
// weight of 1. The blended sum is divided by the weight total, which is 2 or
// 6, and the truncated quotient is registered onto WMA1 one cycle after the
// sample is accepted.
//
// Ports
//   clk       in   1  rising-edge clock
//   rst       in   1  synchronous, active-high reset
//   in_valid  in   1  x / WMA0 / T1 / T2 are valid this cycle
//   x         in   8  new sample, unsigned
//   WMA0      in   8  previous average, unsigned
//   T1        in   8  lower band threshold (inclusive), unsigned
//   T2        in   8  upper band threshold (exclusive), unsigned
//   WMA1      out  8  registered updated average
//   out_valid out  1  one-cycle pulse marking a new WMA1
// ---------------------------------------------------------------------------
module wma_calculator (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] x,
  input  logic [7:0] WMA0,
  input  logic [7:0] T1,
  input  logic [7:0] T2,
  output logic [7:0] WMA1,
  output logic       out_valid
);

  // Fixed divide-by-6 without a runtime divider. For n <= 1530:
  //   floor(n/6) = floor(floor(n/2) / 3)
  // For m = floor(n/2) <= 765:
  //   floor(m/3) = (m * 683) >> 11
  // The reciprocal error of 683/2048 stays below 1/3 LSB over that range, so
  // the result is exact.
  function automatic logic [7:0] div6(input logic [10:0] n);
    logic [9:0]  half;
    logic [19:0] prod;
    half = 10'(n >> 1);
    prod = 20'(half) * 20'd683;
    return 8'(prod >> 11);
  endfunction

  // Internal nets. The names w1, w0, num and denom are probed from outside.
  logic [1:0]  w1;
  logic [1:0]  w0;
  logic [10:0] num;
  logic [2:0]  denom;
  logic        band_s;
  logic [7:0]  quot_s;

  logic [7:0]  wma1_r;
  logic        out_valid_r;

  // Band test and weights. When T1 >= T2 no x can satisfy both compares, so
  // an empty band falls out naturally as weight 1.
  always_comb begin
    band_s = 1'b0;
    w1     = 2'd1;
    w0     = 2'd1;
    if ((x >= T1) && (x < T2)) begin
      band_s = 1'b1;
      w1     = 2'd3;
      w0     = 2'd3;
    end else begin
      band_s = 1'b0;
      w1     = 2'd1;
      w0     = 2'd1;
    end
  end

  // Weighted sum and weight total. The maximum sum is 3*255 + 3*255 = 1530,
  // which fits in 11 bits.
  always_comb begin
    num   = 11'd0;
    denom = 3'd2;
    num   = (11'(w1) * 11'(x)) + (11'(w0) * 11'(WMA0));
    denom = 3'(w1) + 3'(w0);
  end

  // Constant divider selected by the weight total. The total is only ever 2
  // or 6. Any other value falls back to the halving path.
  always_comb begin
    quot_s = 8'd0;
    case (denom)
      3'd2:    quot_s = 8'(num >> 1);
      3'd6:    quot_s = div6(num);
      default: quot_s = 8'(num >> 1);
    endcase
  end

  // Output register. Reset has priority. An idle cycle keeps the average and
  // drops the valid pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      wma1_r      <= 8'd0;
      out_valid_r <= 1'b0;
    end else if (in_valid) begin
      wma1_r      <= quot_s;
      out_valid_r <= 1'b1;
    end else begin
      wma1_r      <= wma1_r;
      out_valid_r <= 1'b0;
    end
  end

  assign WMA1      = wma1_r;
  assign out_valid = out_valid_r;

endmodule

// File: tb/tb_wma_calculator.sv
// ---------------------------------------------------------------------------
// tb_wma_calculator
//
// Directed bench for wma_calculator. A reference model computes each expected
// average with plain integer arithmetic from the band rule. A negedge compare
// process checks WMA1, out_valid and the probed internal nets on every armed
// cycle. Directed vectors also carry hand-computed literal results, which pin
// the model itself.
// ---------------------------------------------------------------------------
module tb_wma_calculator;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [7:0] x;
  logic [7:0] WMA0;
  logic [7:0] T1;
  logic [7:0] T2;
  logic [7:0] WMA1;
  logic       out_valid;

  int vectors = 0;
  int fails   = 0;
  bit armed   = 1'b0;

  // Reference model state, advanced on each rising edge.
  logic [7:0] exp_wma1 = 8'd0;
  logic       exp_ov   = 1'b0;

  wma_calculator dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .x         (x),
    .WMA0      (WMA0),
    .T1        (T1),
    .T2        (T2),
    .WMA1      (WMA1),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Band weight, taken directly from the threshold rule.
  function automatic int weight(input int xv, input int t1v, input int t2v);
    if (xv >= t1v && xv < t2v) return 3;
    return 1;
  endfunction

  // Expected average: floor of the weighted mean.
  function automatic int model_avg(input int xv, input int wv, input int t1v, input int t2v);
    int w;
    w = weight(xv, t1v, t2v);
    return (w * xv + w * wv) / (2 * w);
  endfunction

  task automatic check(input string nm, input logic [10:0] act, input logic [10:0] expv);
    vectors++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // Reference model of the output register.
  always @(posedge clk) begin
    if (rst) begin
      exp_wma1 <= 8'd0;
      exp_ov   <= 1'b0;
    end else if (in_valid) begin
      exp_wma1 <= 8'(model_avg(int'(x), int'(WMA0), int'(T1), int'(T2)));
      exp_ov   <= 1'b1;
    end else begin
      exp_ov   <= 1'b0;
    end
  end

  // Per-cycle compare against the model and the independent weight rule.
  always @(negedge clk) begin
    if (armed) begin
      int w;
      w = weight(int'(x), int'(T1), int'(T2));
      check("cyc_out_valid", 11'(out_valid), 11'(exp_ov));
      check("cyc_wma1", 11'(WMA1), 11'(exp_wma1));
      check("cyc_w1", 11'(dut.w1), 11'(w));
      check("cyc_w0", 11'(dut.w0), 11'(w));
      check("cyc_num", 11'(dut.num), 11'(w * int'(x) + w * int'(WMA0)));
      check("cyc_denom", 11'(dut.denom), 11'(2 * w));
    end
  end

  // Apply one single-cycle sample at posedge+1.
  // Check w1 combinationally, then check the result and that the pulse is
  // exactly one cycle long.
  task automatic vec(input string nm, input logic [7:0] xx, input logic [7:0] ww,
                     input logic [7:0] a, input logic [7:0] b,
                     input logic [1:0] ew, input logic [7:0] er);
    x = xx; WMA0 = ww; T1 = a; T2 = b; in_valid = 1'b1;
    #1;
    check({nm, "_w1"}, 11'(dut.w1), 11'(ew));
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({nm, "_wma1"}, 11'(WMA1), 11'(er));
    check({nm, "_ov"}, 11'(out_valid), 11'd1);
    @(posedge clk); #1;
    check({nm, "_ov_drop"}, 11'(out_valid), 11'd0);
  endtask

  logic [7:0] bx [4];
  logic [7:0] bw [4];
  logic [7:0] br [4];

  initial begin
    rst = 1'b1; in_valid = 1'b0; x = 8'd0; WMA0 = 8'd0; T1 = 8'd75; T2 = 8'd85;
    @(posedge clk); #1;
    armed = 1'b1;
    @(posedge clk); #1;
    check("reset_wma1", 11'(WMA1), 11'd0);
    check("reset_ov", 11'(out_valid), 11'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic and boundary vectors, with T1=75 and T2=85.
    x = 8'd50; WMA0 = 8'd60; #1;
    check("basic_num", 11'(dut.num), 11'd110);
    check("basic_denom", 11'(dut.denom), 11'd2);
    vec("basic",   8'd50,  8'd60,  8'd75, 8'd85, 2'd1, 8'd55);
    x = 8'd80; WMA0 = 8'd70; #1;
    check("band_num", 11'(dut.num), 11'd450);
    check("band_denom", 11'(dut.denom), 11'd6);
    vec("band",    8'd80,  8'd70,  8'd75, 8'd85, 2'd3, 8'd75);
    vec("eq_t1",   8'd75,  8'd85,  8'd75, 8'd85, 2'd3, 8'd80);
    vec("eq_t2",   8'd85,  8'd75,  8'd75, 8'd85, 2'd1, 8'd80);
    vec("t1m1",    8'd74,  8'd74,  8'd75, 8'd85, 2'd1, 8'd74);
    vec("t2m1",    8'd84,  8'd84,  8'd75, 8'd85, 2'd3, 8'd84);
    vec("zero",    8'd0,   8'd0,   8'd75, 8'd85, 2'd1, 8'd0);
    vec("max",     8'd255, 8'd255, 8'd75, 8'd85, 2'd1, 8'd255);
    vec("trunc2",  8'd50,  8'd51,  8'd75, 8'd85, 2'd1, 8'd50);
    vec("trunc6",  8'd76,  8'd77,  8'd75, 8'd85, 2'd3, 8'd76);
    vec("spread",  8'd10,  8'd200, 8'd75, 8'd85, 2'd1, 8'd105);

    // Moved thresholds and an empty band.
    vec("new_t2",  8'd120, 8'd0,   8'd60,  8'd120, 2'd1, 8'd60);
    vec("new_in",  8'd119, 8'd119, 8'd60,  8'd120, 2'd3, 8'd119);
    vec("empty",   8'd80,  8'd90,  8'd100, 8'd50,  2'd1, 8'd85);
    vec("full_in", 8'd255, 8'd1,   8'd0,   8'd255, 2'd1, 8'd128);
    vec("in_lo",   8'd0,   8'd255, 8'd0,   8'd1,   2'd3, 8'd127);

    // Hold: an idle cycle keeps the last result (127).
    repeat (3) begin
      @(posedge clk); #1;
      check("hold_wma1", 11'(WMA1), 11'd127);
      check("hold_ov", 11'(out_valid), 11'd0);
    end

    // Back-to-back samples, with T1=75 and T2=85.
    bx[0] = 8'd50; bw[0] = 8'd60;  br[0] = 8'd55;
    bx[1] = 8'd80; bw[1] = 8'd70;  br[1] = 8'd75;
    bx[2] = 8'd0;  bw[2] = 8'd0;   br[2] = 8'd0;
    bx[3] = 8'd10; bw[3] = 8'd200; br[3] = 8'd105;
    T1 = 8'd75; T2 = 8'd85;
    for (int i = 0; i < 4; i++) begin
      x = bx[i]; WMA0 = bw[i]; in_valid = 1'b1;
      @(posedge clk); #1;
      check("b2b_wma1", 11'(WMA1), 11'(br[i]));
      check("b2b_ov", 11'(out_valid), 11'd1);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("b2b_end_ov", 11'(out_valid), 11'd0);
    check("b2b_end_hold", 11'(WMA1), 11'd105);

    // Reset while a sample is presented: the sample is discarded.
    x = 8'd200; WMA0 = 8'd200; in_valid = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    check("rst_valid_wma1", 11'(WMA1), 11'd0);
    check("rst_valid_ov", 11'(out_valid), 11'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("post_rst_wma1", 11'(WMA1), 11'd200);
    check("post_rst_ov", 11'(out_valid), 11'd1);
    @(posedge clk); #1;

    // Sweep x across one band, to exercise the per-cycle compare.
    T1 = 8'd30; T2 = 8'd40; WMA0 = 8'd35; in_valid = 1'b1;
    for (int i = 25; i < 45; i++) begin
      x = 8'(i);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    armed = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
